// File: rtl/game_state_ctrl.sv
// Game round sequencer: IDLE -> PLAY -> DYING/WIN -> GAMEOVER, with lives and round restarts.
// State, lives and the round_reset/new_game pulses are registered and change one clock after their trigger.
module game_state_ctrl #(
  parameter logic [9:0] TOTAL_PILLS  = 10'd244,
  parameter logic [1:0] START_LIVES  = 2'd3,
  parameter logic [7:0] DEATH_FRAMES = 8'd60
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       start,
  input  logic       frame_tick,
  input  logic [3:0] collision_type,
  input  logic [9:0] pill_count,
  output logic [2:0] state,
  output logic [1:0] lives,
  output logic       play_enable,
  output logic       round_reset,
  output logic       new_game
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PLAY     = 3'd1,
    DYING    = 3'd2,
    WIN      = 3'd3,
    GAMEOVER = 3'd4
  } state_t;

  localparam logic [3:0] COLL_GHOST = 4'b0100;
  localparam logic [7:0] DEATH_LAST = DEATH_FRAMES - 8'd1;

  state_t     state_q, state_nxt;
  logic [1:0] lives_q, lives_nxt;
  logic       round_reset_q, round_reset_nxt;
  logic       new_game_q, new_game_nxt;
  logic [7:0] death_cnt_q;

  logic       start_s1_q, start_s2_q, start_prev_q;
  logic [1:0] sync_fill_q;
  logic       start_armed_q;
  logic       start_rise;

  // The synchronizer only reflects the real button once refilled after reset; a press
  // counts only after a genuine low has been seen, so a button held through reset is ignored.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      start_s1_q    <= 1'b0;
      start_s2_q    <= 1'b0;
      start_prev_q  <= 1'b0;
      sync_fill_q   <= 2'b00;
      start_armed_q <= 1'b0;
    end else begin
      start_s1_q    <= start;
      start_s2_q    <= start_s1_q;
      start_prev_q  <= start_s2_q;
      sync_fill_q   <= {sync_fill_q[0], 1'b1};
      start_armed_q <= start_armed_q | (sync_fill_q[1] & ~start_s2_q);
    end
  end

  assign start_rise = start_s2_q & ~start_prev_q & start_armed_q;

  always_comb begin
    state_nxt       = state_q;
    lives_nxt       = lives_q;
    round_reset_nxt = 1'b0;
    new_game_nxt    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_rise) begin
          state_nxt       = PLAY;
          lives_nxt       = START_LIVES;
          round_reset_nxt = 1'b1;
          new_game_nxt    = 1'b1;
        end
      end
      PLAY: begin
        if (pill_count >= TOTAL_PILLS)
          state_nxt = WIN;
        else if (collision_type == COLL_GHOST)
          state_nxt = DYING;
      end
      DYING: begin
        if (frame_tick && (death_cnt_q == DEATH_LAST)) begin
          if (lives_q <= 2'd1) begin
            state_nxt = GAMEOVER;
            lives_nxt = 2'd0;
          end else begin
            state_nxt       = PLAY;
            lives_nxt       = lives_q - 2'd1;
            round_reset_nxt = 1'b1;
          end
        end
      end
      WIN, GAMEOVER: begin
        if (start_rise)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q       <= IDLE;
      lives_q       <= 2'd0;
      round_reset_q <= 1'b0;
      new_game_q    <= 1'b0;
      death_cnt_q   <= 8'd0;
    end else begin
      state_q       <= state_nxt;
      lives_q       <= lives_nxt;
      round_reset_q <= round_reset_nxt;
      new_game_q    <= new_game_nxt;
      // Held at zero outside DYING so every death starts counting from zero.
      if (state_q != DYING)
        death_cnt_q <= 8'd0;
      else if (frame_tick)
        death_cnt_q <= death_cnt_q + 8'd1;
    end
  end

  assign state       = state_q;
  assign lives       = lives_q;
  assign play_enable = (state_q == PLAY);
  assign round_reset = round_reset_q;
  assign new_game    = new_game_q;

endmodule

// File: tb/tb_game_state_ctrl.sv
// Directed bench for game_state_ctrl: hand-computed expectations for start, deaths, win, reset.
module tb_game_state_ctrl;

  logic       CLOCK_50 = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       frame_tick = 1'b0;
  logic [3:0] collision_type = 4'd0;
  logic [9:0] pill_count = 10'd0;
  logic [2:0] state;
  logic [1:0] lives;
  logic       play_enable;
  logic       round_reset;
  logic       new_game;

  int n_checks = 0;
  int n_errors = 0;
  int rr_seen;

  localparam int S_IDLE = 0, S_PLAY = 1, S_DYING = 2, S_WIN = 3, S_GAMEOVER = 4;

  game_state_ctrl dut (
    .CLOCK_50      (CLOCK_50),
    .reset         (reset),
    .start         (start),
    .frame_tick    (frame_tick),
    .collision_type(collision_type),
    .pill_count    (pill_count),
    .state         (state),
    .lives         (lives),
    .play_enable   (play_enable),
    .round_reset   (round_reset),
    .new_game      (new_game)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  // Synchronizer + edge detect: the state changes on the 3rd edge after start goes high.
  task automatic start_press();
    start = 1'b0;
    repeat (3) tick();
    start = 1'b1;
    repeat (3) tick();
    start = 1'b0;
  endtask

  // Pulses frame_tick n times, counting any round_reset seen along the way.
  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1;
      tick();
      rr_seen += int'(round_reset);
      frame_tick = 1'b0;
      tick();
      rr_seen += int'(round_reset);
    end
  endtask

  // Ghost hit, then 59 frames, then the final frame; returns right after the exit edge.
  task automatic die();
    collision_type = 4'b0100;
    tick();
    collision_type = 4'b0000;
    rr_seen = 0;
    frames(59);
    frame_tick = 1'b1;
    tick();
    frame_tick = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (3) tick();
    check("rst_state", state, S_IDLE);
    check("rst_lives", lives, 0);
    check("rst_play_en", play_enable, 0);
    check("rst_round_reset", round_reset, 0);
    check("rst_new_game", new_game, 0);
    reset = 1'b0;
    repeat (4) tick();
    check("idle_hold", state, S_IDLE);

    // New game
    start_press();
    check("start_state", state, S_PLAY);
    check("start_lives", lives, 3);
    check("start_play_en", play_enable, 1);
    check("start_round_reset", round_reset, 1);
    check("start_new_game", new_game, 1);
    tick();
    check("start_rr_one_cycle", round_reset, 0);
    check("start_ng_one_cycle", new_game, 0);

    // Pill and unrelated collision codes are ignored
    pill_count = 10'd100;
    collision_type = 4'b0010;
    tick();
    check("pill_state", state, S_PLAY);
    check("pill_lives", lives, 3);
    collision_type = 4'b0110;
    tick();
    check("code6_state", state, S_PLAY);
    collision_type = 4'b0000;
    pill_count = 10'd243;
    tick();
    check("pill243_state", state, S_PLAY);
    pill_count = 10'd0;

    // First death with start and ghost during DYING ignored
    collision_type = 4'b0100;
    tick();
    collision_type = 4'b0000;
    check("ghost_state", state, S_DYING);
    check("ghost_play_en", play_enable, 0);
    rr_seen = 0;
    frames(30);
    start = 1'b1;
    collision_type = 4'b0100;
    repeat (4) tick();
    start = 1'b0;
    collision_type = 4'b0000;
    repeat (4) tick();
    check("dying_ignores_start_ghost", state, S_DYING);
    frames(29);
    check("dying_59_frames", state, S_DYING);
    check("dying_59_lives", lives, 3);
    check("dying_no_rr", rr_seen, 0);
    frame_tick = 1'b1;
    tick();
    frame_tick = 1'b0;
    check("death1_state", state, S_PLAY);
    check("death1_lives", lives, 2);
    check("death1_rr", round_reset, 1);
    check("death1_ng", new_game, 0);
    tick();
    check("death1_rr_one_cycle", round_reset, 0);

    // Second and third deaths
    die();
    check("death2_state", state, S_PLAY);
    check("death2_lives", lives, 1);
    check("death2_rr", round_reset, 1);
    tick();
    die();
    check("death3_state", state, S_GAMEOVER);
    check("death3_lives", lives, 0);
    check("death3_rr", round_reset, 0);
    check("death3_ng", new_game, 0);
    tick();
    check("gameover_hold", state, S_GAMEOVER);
    check("gameover_play_en", play_enable, 0);

    // GAMEOVER -> IDLE on start, no pulses
    start_press();
    check("go_idle_state", state, S_IDLE);
    check("go_idle_rr", round_reset, 0);
    check("go_idle_lives", lives, 0);

    // Win beats ghost in the same cycle
    start_press();
    check("game2_lives", lives, 3);
    tick();
    pill_count = 10'd244;
    collision_type = 4'b0100;
    tick();
    collision_type = 4'b0000;
    check("win_state", state, S_WIN);
    check("win_lives", lives, 3);
    check("win_play_en", play_enable, 0);
    start_press();
    check("win_idle_state", state, S_IDLE);
    check("win_idle_rr", round_reset, 0);
    check("win_idle_lives", lives, 3);
    pill_count = 10'd0;

    // Reset in the middle of DYING, start held through reset release
    start_press();
    tick();
    collision_type = 4'b0100;
    tick();
    collision_type = 4'b0000;
    frames(30);
    check("mid_dying_state", state, S_DYING);
    reset = 1'b1;
    start = 1'b1;
    tick();
    check("mid_rst_state", state, S_IDLE);
    check("mid_rst_lives", lives, 0);
    check("mid_rst_rr", round_reset, 0);
    tick();
    reset = 1'b0;
    repeat (6) tick();
    check("held_start_no_rise", state, S_IDLE);
    start_press();
    check("restart_state", state, S_PLAY);
    check("restart_lives", lives, 3);
    check("restart_ng", new_game, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
